// File: rtl/msk_gf2n_mul_hpc1_pipe_if.sv
// Operand/result bus of the masked GF(2^N) HPC1 multiplier pipeline.
// slave is the multiplier side; master is the producer/consumer side.
interface msk_gf2n_mul_hpc1_pipe_if #(
  parameter int unsigned d     = 2,
  parameter int unsigned N     = 4,
  parameter int unsigned RND_W = N * d * (d - 1) / 2
);
  logic             in_valid;
  logic             in_ready;
  logic [d*N-1:0]   in_a;
  logic [d*N-1:0]   in_b;
  logic [RND_W-1:0] rnd_ref;
  logic [RND_W-1:0] rnd_mul;
  logic             out_valid;
  logic             out_ready;
  logic [d*N-1:0]   out_c;

  modport slave (
    input  in_valid, in_a, in_b, rnd_ref, rnd_mul, out_ready,
    output in_ready, out_valid, out_c
  );

  modport master (
    output in_valid, in_a, in_b, rnd_ref, rnd_mul, out_ready,
    input  in_ready, out_valid, out_c
  );
endinterface

// File: rtl/msk_gf2n_mul_hpc1_pipe.sv
// Masked d-share GF(2^N) multiplier (HPC1): SNI refresh of B in stage 1, DOM product in stage 2,
// behind a two-stage valid/ready pipe with a global stall.
module msk_gf2n_mul_hpc1_pipe #(
  parameter int unsigned d    = 2,
  parameter int unsigned N    = 4,
  parameter logic [N:0]  POLY = 5'h13
) (
  input  logic                     clk,
  input  logic                     rst,
  msk_gf2n_mul_hpc1_pipe_if.slave  bus
);
  localparam int unsigned RND_W = N * d * (d - 1) / 2;
  localparam int unsigned DN    = d * N;
  localparam int unsigned PW    = 2 * N - 1;

  logic             adv;
  logic [RND_W-1:0] rnd_ref;
  logic [RND_W-1:0] rnd_mul;
  logic [DN-1:0]    b_ref;
  logic [N-1:0]     term;
  logic [d*DN-1:0]  p_new;
  logic [DN-1:0]    out_c;

  logic             v1_d, v1_q, v2_d, v2_q;
  logic [DN-1:0]    a1_d, a1_q, b1_d, b1_q;
  logic [d*DN-1:0]  p_d, p_q;

  // Carry-less product followed by reduction modulo POLY, from the top bit down.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [PW-1:0] prod;
    logic [PW-1:0] poly_ext;
    prod     = '0;
    poly_ext = PW'(POLY);
    for (int i = 0; i < int'(N); i++) begin
      if (y[i]) prod ^= PW'(x) << i;
    end
    for (int k = int'(PW) - 1; k >= int'(N); k--) begin
      if (prod[k]) prod ^= poly_ext << (k - int'(N));
    end
    return prod[N-1:0];
  endfunction

  // Slot of unordered pair (lo<hi) in the packed randomness vectors.
  function automatic int unsigned pair_idx(input int unsigned lo, input int unsigned hi);
    return lo * (2 * d - lo - 1) / 2 + (hi - lo - 1);
  endfunction

  assign rnd_ref = bus.rnd_ref;
  assign rnd_mul = bus.rnd_mul;

  always_comb begin
    adv   = ~v2_q | bus.out_ready;
    b_ref = bus.in_b;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = i + 1; j < d; j++) begin
        b_ref[i*N +: N] ^= rnd_ref[pair_idx(i, j)*N +: N];
        b_ref[j*N +: N] ^= rnd_ref[pair_idx(i, j)*N +: N];
      end
    end

    // Each cross term is masked and registered on its own; no share mixing happens here.
    term  = '0;
    p_new = '0;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d; j++) begin
        term = gf_mul(a1_q[i*N +: N], b1_q[j*N +: N]);
        if (i < j) term ^= rnd_mul[pair_idx(i, j)*N +: N];
        if (i > j) term ^= rnd_mul[pair_idx(j, i)*N +: N];
        p_new[(i*d+j)*N +: N] = term;
      end
    end

    v1_d = adv ? bus.in_valid : v1_q;
    a1_d = adv ? bus.in_a     : a1_q;
    b1_d = adv ? b_ref        : b1_q;
    v2_d = adv ? v1_q         : v2_q;
    p_d  = adv ? p_new        : p_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      v2_q <= 1'b0;
      p_q  <= '0;
    end else begin
      v1_q <= v1_d;
      a1_q <= a1_d;
      b1_q <= b1_d;
      v2_q <= v2_d;
      p_q  <= p_d;
    end
  end

  // Share compression: only after the stage-2 registers.
  always_comb begin
    out_c = '0;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d; j++) begin
        out_c[i*N +: N] ^= p_q[(i*d+j)*N +: N];
      end
    end
  end

  assign bus.out_c     = out_c;
  assign bus.out_valid = v2_q;
  assign bus.in_ready  = adv;
endmodule
